// File: rtl/find_bw_pkg.sv
// Shared types and default sizing for the bandwidth left-edge finder.
// Holds the search FSM encoding and the default widths.
package find_bw_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PEAK = 2'd1,
    S_SCAN = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int ACCUM_WIDTH_DEF    = 18;
  localparam int FREQ_BIN_WIDTH_DEF = 16;
  localparam int THRESHOLD_DB_DEF   = 7680;
  localparam int NUM_ACCUMS_DEF     = 24;

endpackage

// File: rtl/find_bw_left_edge.sv
// Finds the spectrum peak, then walks left to the first point
// that falls strictly below (peak - threshold).
module find_bw_left_edge
  import find_bw_pkg::*;
#(
  parameter int ACCUM_WIDTH    = ACCUM_WIDTH_DEF,
  parameter int FREQ_BIN_WIDTH = FREQ_BIN_WIDTH_DEF,
  parameter int THRESHOLD_DB   = THRESHOLD_DB_DEF,
  parameter int NUM_ACCUMS     = NUM_ACCUMS_DEF
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     start_i,
  input  logic [NUM_ACCUMS*ACCUM_WIDTH-1:0]        accumulator_val_i,
  input  logic [NUM_ACCUMS*FREQ_BIN_WIDTH-1:0]     freq_bin_i,
  output logic [FREQ_BIN_WIDTH-1:0]                f1_o,
  output logic [FREQ_BIN_WIDTH-1:0]                f2_o,
  output logic signed [ACCUM_WIDTH-1:0]            L1_o,
  output logic signed [ACCUM_WIDTH-1:0]            L2_o,
  output logic                                     valid_o,
  output logic                                     busy_o
);

  localparam int AW = ACCUM_WIDTH;
  localparam int FW = FREQ_BIN_WIDTH;
  localparam int IW = $clog2(NUM_ACCUMS);

  localparam logic [IW-1:0]        LAST = IW'(NUM_ACCUMS - 1);
  localparam logic [IW-1:0]        ONE  = IW'(1);
  localparam logic signed [AW:0]   THR  = (AW+1)'(THRESHOLD_DB);

  logic signed [AW-1:0] acc_a [NUM_ACCUMS];
  logic [FW-1:0]        fb_a  [NUM_ACCUMS];

  always_comb begin
    for (int i = 0; i < NUM_ACCUMS; i++) begin
      acc_a[i] = accumulator_val_i[i*AW +: AW];
      fb_a[i]  = freq_bin_i[i*FW +: FW];
    end
  end

  state_e               state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [IW-1:0]        pidx_q, pidx_d;
  logic signed [AW-1:0] peak_q, peak_d;
  logic [FW-1:0]        f1_q, f1_d, f2_q, f2_d;
  logic signed [AW-1:0] l1_q, l1_d, l2_q, l2_d;
  logic                 valid_q, valid_d;

  logic [IW-1:0]        idx_p1;
  logic signed [AW-1:0] cur, nxt;
  logic signed [AW:0]   cur_x, level;

  assign idx_p1 = idx_q + ONE;
  assign cur    = acc_a[idx_q];
  assign nxt    = acc_a[idx_p1];
  assign cur_x  = {cur[AW-1], cur};
  // One extra bit so the level never wraps.
  assign level  = {peak_q[AW-1], peak_q} - THR;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pidx_d  = pidx_q;
    peak_d  = peak_q;
    f1_d    = f1_q;
    f2_d    = f2_q;
    l1_d    = l1_q;
    l2_d    = l2_q;
    valid_d = valid_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          valid_d = 1'b0;
          peak_d  = acc_a[0];
          pidx_d  = '0;
          idx_d   = ONE;
          state_d = S_PEAK;
        end
      end
      S_PEAK: begin
        if (cur > peak_q) begin
          peak_d = cur;
          pidx_d = idx_q;
        end
        if (idx_q == LAST) begin
          if (pidx_d == '0) begin
            f1_d    = fb_a[0];
            f2_d    = fb_a[0];
            l1_d    = acc_a[0];
            l2_d    = acc_a[0];
            valid_d = 1'b1;
            state_d = S_DONE;
          end else begin
            idx_d   = pidx_d - ONE;
            state_d = S_SCAN;
          end
        end else begin
          idx_d = idx_p1;
        end
      end
      S_SCAN: begin
        if (cur_x < level) begin
          f1_d    = fb_a[idx_q];
          f2_d    = fb_a[idx_p1];
          l1_d    = cur;
          l2_d    = nxt;
          valid_d = 1'b1;
          state_d = S_DONE;
        end else if (idx_q == '0) begin
          f1_d    = fb_a[0];
          f2_d    = fb_a[0];
          l1_d    = acc_a[0];
          l2_d    = acc_a[0];
          valid_d = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      pidx_q  <= '0;
      peak_q  <= '0;
      f1_q    <= '0;
      f2_q    <= '0;
      l1_q    <= '0;
      l2_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pidx_q  <= pidx_d;
      peak_q  <= peak_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      l1_q    <= l1_d;
      l2_q    <= l2_d;
      valid_q <= valid_d;
    end
  end

  assign f1_o    = f1_q;
  assign f2_o    = f2_q;
  assign L1_o    = l1_q;
  assign L2_o    = l2_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q == S_PEAK) || (state_q == S_SCAN);

endmodule

// File: tb/tb_find_bw_left_edge.sv
// Directed bench for find_bw_left_edge with immediate assertions.
// Expected values are hand-computed from the ramp/peak patterns.
module tb_find_bw_left_edge;

  localparam int N  = 24;
  localparam int AW = 18;
  localparam int FW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [N*AW-1:0]   acc = '0;
  logic [N*FW-1:0]   fb = '0;
  logic [FW-1:0]     f1, f2;
  logic signed [AW-1:0] l1, l2;
  logic              valid, busy;

  int checks = 0;
  int errors = 0;
  int rises = 0;
  int lat;
  logic vprev = 1'b0;

  find_bw_left_edge dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .accumulator_val_i (acc),
    .freq_bin_i        (fb),
    .f1_o              (f1),
    .f2_o              (f2),
    .L1_o              (l1),
    .L2_o              (l2),
    .valid_o           (valid),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (valid && !vprev) rises++;
    vprev = valid;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_pt(input int i, input int v, input int f);
    acc[i*AW +: AW] = AW'(v);
    fb[i*FW +: FW]  = FW'(f);
  endtask

  task automatic load_ramp();
    for (int i = 0; i < N; i++)
      set_pt(i, (i <= 12) ? -(12 - i) * 1024 : -(i - 12) * 1024, i * 100);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (valid) begin
        cyc = k;
        break;
      end
    end
    chk({tag, "_valid"}, {31'd0, valid}, 32'd1);
  endtask

  task automatic chk_res(input string tag, input logic [31:0] ef1,
                         input logic [31:0] ef2, input logic [31:0] el1,
                         input logic [31:0] el2);
    chk({tag, "_f1"}, {16'd0, f1}, ef1);
    chk({tag, "_f2"}, {16'd0, f2}, ef2);
    chk({tag, "_L1"}, {14'd0, l1}, el1);
    chk({tag, "_L2"}, {14'd0, l2}, el2);
  endtask

  initial begin
    load_ramp();
    repeat (3) @(negedge clk);
    chk_res("rst", 32'h0, 32'h0, 32'h0, 32'h0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Basic ramp, peak at 12.
    pulse_start();
    chk("ramp_busy", {31'd0, busy}, 32'd1);
    wait_valid("ramp", lat);
    chk("ramp_lat_ok", {31'd0, (lat > 0 && lat <= N + 12 + 2)}, 32'd1);
    chk_res("ramp", 32'h190, 32'h1F4, 32'h3E000, 32'h3E400);
    chk("ramp_busy_done", {31'd0, busy}, 32'd0);

    // Equality at the level is not a crossing.
    set_pt(5, -7680, 500);
    pulse_start();
    wait_valid("eq", lat);
    chk_res("eq", 32'h190, 32'h1F4, 32'h3E000, 32'h3E200);

    // Peak at index 0.
    for (int i = 0; i < N; i++) set_pt(i, -i * 512, 16'h1000 + i);
    pulse_start();
    wait_valid("p0", lat);
    chk_res("p0", 32'h1000, 32'h1000, 32'h0, 32'h0);

    // Flat spectrum.
    for (int i = 0; i < N; i++) set_pt(i, -512, 16'h2000 + i);
    pulse_start();
    wait_valid("flat", lat);
    chk_res("flat", 32'h2000, 32'h2000, 32'h3FE00, 32'h3FE00);

    // Peak at 5 with no crossing to its left.
    set_pt(5, 0, 16'h2005);
    pulse_start();
    wait_valid("nocross", lat);
    chk_res("nocross", 32'h2000, 32'h2000, 32'h3FE00, 32'h3FE00);

    // start_i re-pulsed while busy is ignored.
    load_ramp();
    pulse_start();
    rises = 0;
    repeat (5) @(negedge clk);
    chk("rep_busy", {31'd0, busy}, 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("rep", lat);
    repeat (5) @(negedge clk);
    chk_res("rep", 32'h190, 32'h1F4, 32'h3E000, 32'h3E400);
    chk("rep_rises", rises, 32'd1);

    // Reset during SCAN aborts the search.
    pulse_start();
    rises = 0;
    repeat (26) @(negedge clk);
    chk("abort_busy_pre", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, valid}, 32'd0);
    chk_res("abort", 32'h0, 32'h0, 32'h0, 32'h0);
    repeat (20) @(negedge clk);
    chk("abort_rises", rises, 32'd0);
    pulse_start();
    wait_valid("fresh", lat);
    chk_res("fresh", 32'h190, 32'h1F4, 32'h3E000, 32'h3E400);

    // Back-to-back search with new inputs, peak at 20.
    for (int i = 0; i < N; i++)
      set_pt(i, (i <= 20) ? -(20 - i) * 2048 : -4096, i * 100);
    pulse_start();
    chk("b2b_valid_drop", {31'd0, valid}, 32'd0);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_valid("b2b", lat);
    chk("b2b_lat_ok", {31'd0, (lat > 0 && lat <= N + 20 + 2)}, 32'd1);
    chk_res("b2b", 32'h640, 32'h6A4, 32'h3E000, 32'h3E800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/find_bw_left_edge.md
FIND_BW_LEFT_EDGE -- requirements
Module: find_bw_left_edge

Interface
REQ-001 SHALL have parameter ACCUM_WIDTH, default 18: signed power-value width, dB in Q(ACCUM_WIDTH-8).8.
REQ-002 SHALL have parameter FREQ_BIN_WIDTH, default 16: unsigned frequency-bin label width.
REQ-003 SHALL have parameter THRESHOLD_DB, default 7680: positive drop below the peak, Q8.8 (7680 = 30.0 dB).
REQ-004 SHALL have parameter NUM_ACCUMS, default 24: number of spectrum points, at least 2.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start_i, input, 1 bit: request one search.
REQ-008 SHALL have port accumulator_val_i, input, NUM_ACCUMS x ACCUM_WIDTH signed: power per point.
REQ-009 SHALL have port freq_bin_i, input, NUM_ACCUMS x FREQ_BIN_WIDTH: frequency label per point.
REQ-010 SHALL have port f1_o, output, FREQ_BIN_WIDTH: label of the first point below the level.
REQ-011 SHALL have port f2_o, output, FREQ_BIN_WIDTH: label of its right neighbour.
REQ-012 SHALL have port L1_o, output, ACCUM_WIDTH signed: power at f1_o.
REQ-013 SHALL have port L2_o, output, ACCUM_WIDTH signed: power at f2_o.
REQ-014 SHALL have port valid_o, output, 1 bit: result available.
REQ-015 SHALL have port busy_o, output, 1 bit: search in progress.

Function
REQ-016 SHALL implement FSM IDLE -> PEAK -> SCAN -> DONE. busy_o is high in PEAK and SCAN only.
REQ-017 SHALL accept start_i only in IDLE or DONE; start_i in PEAK or SCAN is ignored.
REQ-018 On the accept edge the block SHALL clear valid_o, set peak = accumulator_val_i[0] and peak index = 0, and enter PEAK.
REQ-019 PEAK SHALL examine indices 1..NUM_ACCUMS-1, one per cycle, and update the peak only on a strictly greater value (first maximum wins).
REQ-020 Level SHALL be computed as peak - THRESHOLD_DB at ACCUM_WIDTH+1 bits signed; it is never saturated or wrapped.
REQ-021 SCAN SHALL start at peak index - 1 and decrement one index per cycle.
REQ-022 A point i is a crossing when accumulator_val_i[i] < level (strictly less). At the first crossing the block SHALL register:
- f1_o = freq_bin_i[i], L1_o = accumulator_val_i[i];
- f2_o = freq_bin_i[i+1], L2_o = accumulator_val_i[i+1];
- then enter DONE.
REQ-023 If no crossing is found down to index 0, or the peak index is 0, the block SHALL register f1_o = f2_o = freq_bin_i[0] and L1_o = L2_o = accumulator_val_i[0], then enter DONE.
REQ-024 In DONE, valid_o SHALL be 1 and outputs SHALL hold until the next accepted start_i or reset.
REQ-025 valid_o SHALL rise no later than NUM_ACCUMS + peak index + 2 cycles after the accept edge.
REQ-026 Inputs are read combinationally by index; the upstream SHALL hold them stable while busy_o is high.

Reset
REQ-027 While rst_i is high at a clock edge:
- the state SHALL go to IDLE;
- f1_o, f2_o, L1_o, L2_o and the internal peak/index SHALL be 0;
- valid_o and busy_o SHALL be 0.
REQ-028 Reset mid-search SHALL abort the search with no valid_o pulse.

Structure
REQ-029 Package find_bw_pkg SHALL hold the FSM state enum and the default width/size constants.
REQ-030 No sub-module SHALL be used; a single module with a ceil(log2(NUM_ACCUMS))-bit index counter and peak register.

Verification
REQ-031 Ramp: accum[i] = -(12-i)*1024 for i <= 12, accum[i] = -(i-12)*1024 for i > 12; freq_bin[i] = i*100 -> f1=0x0190, f2=0x01F4, L1=0x3E000, L2=0x3E400, valid_o=1.
REQ-032 Same ramp but accum[5] = -7680 exactly -> f1=0x0190, L1=0x3E000, f2=0x01F4, L2=0x3E200 (equality is not a crossing).
REQ-033 Peak at index 0, or flat spectrum of all -512 -> f1=f2=freq_bin[0], L1=L2=accum[0], valid_o=1.
REQ-034 start_i re-pulsed while busy_o=1 -> ignored; the result is identical to REQ-031 and valid_o rises once.
REQ-035 rst_i asserted during SCAN -> next cycle busy_o=0, valid_o=0, all outputs 0; a fresh start_i then reproduces REQ-031.
REQ-036 Back-to-back searches -> valid_o drops on the accept edge, and the second result reflects the new inputs.
